// File: rtl/bk_intc_pkg.sv
// bk_intc_pkg: shared constants and packed-field helpers for the BK vectored
// interrupt controller.
//   PRIO_W / VEC_W : width of one priority / vector field
//   MAX_CH         : largest supported channel count
//   REG_ENABLE / REG_PENDING : offsets inside the two-word register window
//   prio_of / vec_of : extract channel i from a packed parameter table that
//                      has been zero-extended to MAX_CH entries
package bk_intc_pkg;

    localparam int PRIO_W = 3;
    localparam int VEC_W  = 16;
    localparam int MAX_CH = 8;

    localparam logic REG_ENABLE  = 1'b0;
    localparam logic REG_PENDING = 1'b1;

    function automatic logic [PRIO_W-1:0] prio_of(
        input logic [MAX_CH*PRIO_W-1:0] prio,
        input int                       i
    );
        return prio[i*PRIO_W +: PRIO_W];
    endfunction

    function automatic logic [VEC_W-1:0] vec_of(
        input logic [MAX_CH*VEC_W-1:0] vectors,
        input int                      i
    );
        return vectors[i*VEC_W +: VEC_W];
    endfunction

endpackage

// File: rtl/bk_intc_arb.sv
// bk_intc_arb: combinational winner select among candidate channels.
//   cand     : channels currently requesting (pending & enabled)
//   prio_tab : packed priority per channel, channel i at [3i+2:3i]
//   valid    : at least one candidate exists
//   idx      : winning channel (highest priority, lowest index on a tie)
//   prio     : priority of the winner
module bk_intc_arb
    import bk_intc_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]        cand,
    input  logic [NCH*PRIO_W-1:0] prio_tab,
    output logic                  valid,
    output logic [2:0]            idx,
    output logic [PRIO_W-1:0]     prio
);

    logic [MAX_CH*PRIO_W-1:0] prio_ext;
    assign prio_ext = (MAX_CH*PRIO_W)'(prio_tab);

    // Scanning upward and replacing only on strictly higher priority keeps
    // the lowest index among equal-priority candidates.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        prio  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cand[i] && (!valid || prio_of(prio_ext, i) > prio)) begin
                valid = 1'b1;
                idx   = 3'(i);
                prio  = prio_of(prio_ext, i);
            end
        end
    end

endmodule

// File: rtl/bk_intc.sv
// bk_intc: parametrised vectored interrupt controller for the BK core.
//   clk, reset      : core clock, synchronous active-high reset
//   ce              : clock enable for all state except reset
//   src_i           : per-channel request lines
//   psw_pri         : current CPU priority (PSW[7:5])
//   virq_o          : vectored interrupt request to the CPU
//   iako_i          : interrupt acknowledge, held through the vector read
//   vector_o        : vector latched at the start of the acknowledge
//   reg_*           : two-word register window (enable / pending)
//   ack_ch_o        : channel index of the last acknowledge
module bk_intc
    import bk_intc_pkg::*;
#(
    parameter int                      NCH          = 4,
    parameter logic [NCH*PRIO_W-1:0]   PRIO         = {3'd4, 3'd4, 3'd4, 3'd4},
    parameter logic [NCH*VEC_W-1:0]    VECTORS      = {16'o0100, 16'o0274, 16'o0060, 16'o0060},
    parameter logic [NCH-1:0]          EDGE_MASK    = 4'b0011,
    parameter logic [NCH-1:0]          ENABLE_RST   = 4'b0001,
    parameter logic [VEC_W-1:0]        SPURIOUS_VEC = 16'o0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [NCH-1:0]    src_i,
    input  logic [2:0]        psw_pri,
    output logic              virq_o,
    input  logic              iako_i,
    output logic [VEC_W-1:0]  vector_o,
    input  logic              reg_sel,
    input  logic              reg_adr,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [15:0]       reg_di,
    output logic [15:0]       reg_do,
    output logic [2:0]        ack_ch_o
);

    localparam logic [MAX_CH*VEC_W-1:0] VEC_EXT = (MAX_CH*VEC_W)'(VECTORS);

    logic [NCH-1:0]    src_q, pending, enable, pending_nx, clr;
    logic              iako_q, virq_q, ack_fire, wr_en;
    logic              win_valid;
    logic [2:0]        win_idx;
    logic [PRIO_W-1:0] win_prio;

    // Write data above the channel count carries nothing.
    logic unused_di;
    assign unused_di = ^reg_di[15:NCH];

    assign ack_fire = iako_i & ~iako_q;
    assign wr_en    = reg_sel & reg_wr;

    bk_intc_arb #(.NCH(NCH)) u_arb (
        .cand     (pending & enable),
        .prio_tab (PRIO),
        .valid    (win_valid),
        .idx      (win_idx),
        .prio     (win_prio)
    );

    // Edge channels: a new rising edge beats any clear in the same cycle.
    // Level channels simply mirror the source one cycle late.
    always_comb begin
        clr        = '0;
        pending_nx = '0;
        for (int i = 0; i < NCH; i++) begin
            clr[i] = EDGE_MASK[i] &
                     ((ack_fire & win_valid & (win_idx == 3'(i))) |
                      (wr_en & (reg_adr == REG_PENDING) & reg_di[i]));
            if (EDGE_MASK[i])
                pending_nx[i] = (src_i[i] & ~src_q[i]) | (pending[i] & ~clr[i]);
            else
                pending_nx[i] = src_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            pending  <= '0;
            enable   <= ENABLE_RST;
            iako_q   <= 1'b0;
            virq_q   <= 1'b0;
            vector_o <= '0;
            ack_ch_o <= '0;
        end else if (ce) begin
            src_q   <= src_i;
            pending <= pending_nx;
            iako_q  <= iako_i;
            virq_q  <= win_valid & (win_prio > psw_pri) & ~iako_i;
            if (wr_en && reg_adr == REG_ENABLE)
                enable <= reg_di[NCH-1:0];
            // The vector is captured once at the start of the acknowledge so
            // it cannot change under the CPU while it reads it.
            if (ack_fire) begin
                if (win_valid) begin
                    vector_o <= vec_of(VEC_EXT, int'(win_idx));
                    ack_ch_o <= win_idx;
                end else begin
                    vector_o <= SPURIOUS_VEC;
                end
            end
        end
    end

    // The request is masked immediately when the CPU starts acknowledging,
    // not one cycle later.
    assign virq_o = virq_q & ~iako_i;

    always_comb begin
        reg_do = '0;
        if (reg_sel && reg_rd) begin
            if (reg_adr == REG_ENABLE) begin
                reg_do[NCH-1:0] = enable;
            end else begin
                reg_do[NCH-1:0]  = pending;
                reg_do[8 +: NCH] = src_i & ~EDGE_MASK;
            end
        end
    end

endmodule

// File: tb/tb_bk_intc.sv
// tb_bk_intc: table-driven bench for bk_intc plus hand sequences for
// set/clear collisions, clock-enable gating and level-channel write masking.
// Configuration: ch0 edge P4 0060, ch1 edge P4 0274, ch2 level P4 0200,
// ch3 level P6 0100.
module tb_bk_intc;

    logic        clk = 1'b0;
    logic        reset, ce, iako_i, reg_sel, reg_adr, reg_wr, reg_rd;
    logic [3:0]  src_i;
    logic [2:0]  psw_pri, ack_ch_o;
    logic        virq_o;
    logic [15:0] vector_o, reg_di, reg_do;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bk_intc #(
        .NCH          (4),
        .PRIO         ({3'd6, 3'd4, 3'd4, 3'd4}),
        .VECTORS      ({16'o0100, 16'o0200, 16'o0274, 16'o0060}),
        .EDGE_MASK    (4'b0011),
        .ENABLE_RST   (4'b0001),
        .SPURIOUS_VEC (16'o0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .src_i    (src_i),
        .psw_pri  (psw_pri),
        .virq_o   (virq_o),
        .iako_i   (iako_i),
        .vector_o (vector_o),
        .reg_sel  (reg_sel),
        .reg_adr  (reg_adr),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_di   (reg_di),
        .reg_do   (reg_do),
        .ack_ch_o (ack_ch_o)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  src;
        logic [2:0]  psw;
        logic        iako;
        logic        adr;
        logic        wr;
        logic [15:0] di;
        logic        e_virq;
        logic [15:0] e_vec;
        logic [2:0]  e_ack;
        logic [15:0] e_do;
    } row_t;

    row_t tv[$];

    function automatic row_t mk(logic rst, logic [3:0] src, logic [2:0] psw,
                                logic iako, logic adr, logic wr, logic [15:0] di,
                                logic ev, logic [15:0] evec, logic [2:0] eack,
                                logic [15:0] edo);
        row_t r;
        r.rst = rst; r.src = src; r.psw = psw; r.iako = iako; r.adr = adr;
        r.wr = wr; r.di = di; r.e_virq = ev; r.e_vec = evec; r.e_ack = eack;
        r.e_do = edo;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then settle past the edge.
    task automatic step(logic c, logic [3:0] s, logic [2:0] p, logic ia,
                        logic a, logic w, logic [15:0] d);
        ce = c; src_i = s; psw_pri = p; iako_i = ia;
        reg_adr = a; reg_wr = w; reg_di = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b1; src_i = '0; psw_pri = '0; iako_i = 1'b0;
        reg_sel = 1'b1; reg_rd = 1'b1; reg_adr = 1'b1; reg_wr = 1'b0; reg_di = '0;

        //               rst src psw ia adr wr di      virq vec     ack do
        tv.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0,   0, 16'h00, 0, 16'h000)); // reset
        tv.push_back(mk(0, 1, 0, 0, 1, 0, 16'h0,   0, 16'h00, 0, 16'h001)); // ch0 edge
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   1, 16'h00, 0, 16'h001));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0,   0, 16'h30, 0, 16'h000)); // ack ch0
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h000));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 16'h3,   0, 16'h30, 0, 16'h003)); // enable=3
        tv.push_back(mk(0, 3, 0, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h003)); // ch0+ch1
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   1, 16'h30, 0, 16'h003));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0,   0, 16'h30, 0, 16'h002)); // tie -> ch0
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   1, 16'h30, 0, 16'h002));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0,   0, 16'hBC, 1, 16'h000)); // then ch1
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   0, 16'hBC, 1, 16'h000));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 16'h9,   0, 16'hBC, 1, 16'h009)); // enable=9
        tv.push_back(mk(0, 8, 6, 0, 1, 0, 16'h0,   0, 16'hBC, 1, 16'h808)); // ch3 level
        tv.push_back(mk(0, 8, 6, 0, 1, 0, 16'h0,   0, 16'hBC, 1, 16'h808)); // 6 !> 6
        tv.push_back(mk(0, 8, 5, 0, 1, 0, 16'h0,   1, 16'hBC, 1, 16'h808)); // psw 5
        tv.push_back(mk(0, 9, 5, 0, 1, 0, 16'h0,   1, 16'hBC, 1, 16'h809)); // + ch0
        tv.push_back(mk(0, 8, 5, 0, 1, 0, 16'h0,   1, 16'hBC, 1, 16'h809));
        tv.push_back(mk(0, 8, 5, 1, 1, 0, 16'h0,   0, 16'h40, 3, 16'h809)); // ack ch3
        tv.push_back(mk(0, 0, 5, 0, 1, 0, 16'h0,   1, 16'h40, 3, 16'h001)); // ch3 drops
        tv.push_back(mk(0, 0, 5, 0, 1, 0, 16'h0,   0, 16'h40, 3, 16'h001)); // 4 !> 5
        tv.push_back(mk(0, 0, 3, 0, 1, 0, 16'h0,   1, 16'h40, 3, 16'h001));
        tv.push_back(mk(0, 0, 3, 1, 1, 0, 16'h0,   0, 16'h30, 0, 16'h000)); // ack ch0
        tv.push_back(mk(0, 0, 3, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h000));
        tv.push_back(mk(0, 2, 0, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h002)); // ch1 disabled
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h002));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 16'h2,   0, 16'h30, 0, 16'h000)); // W1C ch1
        tv.push_back(mk(0, 2, 0, 0, 1, 0, 16'h0,   0, 16'h30, 0, 16'h002)); // re-pulse
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 16'hB,   0, 16'h30, 0, 16'h00B)); // enable ch1
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   1, 16'h30, 0, 16'h002));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 16'h9,   1, 16'h30, 0, 16'h009)); // disable ch1
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0,   0, 16'h00, 0, 16'h002)); // spurious
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   0, 16'h00, 0, 16'h002));
        tv.push_back(mk(0, 1, 0, 0, 1, 0, 16'h0,   0, 16'h00, 0, 16'h003));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0,   0, 16'h30, 0, 16'h002)); // ack ch0
        tv.push_back(mk(0, 1, 0, 1, 1, 0, 16'h0,   0, 16'h30, 0, 16'h003)); // held ack
        tv.push_back(mk(1, 0, 0, 1, 1, 0, 16'h0,   0, 16'h00, 0, 16'h000)); // reset in ack
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0,   0, 16'h00, 0, 16'h001)); // enable=1
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0,   0, 16'h00, 0, 16'h000));

        foreach (tv[i]) begin
            reset = tv[i].rst;
            step(1'b1, tv[i].src, tv[i].psw, tv[i].iako, tv[i].adr, tv[i].wr, tv[i].di);
            chk($sformatf("row%0d virq", i), 16'(virq_o), 16'(tv[i].e_virq));
            chk($sformatf("row%0d vector", i), vector_o, tv[i].e_vec);
            chk($sformatf("row%0d ack_ch", i), 16'(ack_ch_o), 16'(tv[i].e_ack));
            chk($sformatf("row%0d reg_do", i), reg_do, tv[i].e_do);
        end
        reset = 1'b0;

        // Set vs write-1-to-clear on ch1 in the same cycle: set wins.
        step(1, 4'h0, 0, 0, 0, 1, 16'h3);
        step(1, 4'h2, 0, 0, 1, 1, 16'h2);
        chk("collide_w1c pending", reg_do, 16'h002);

        // Set vs acknowledge clear on ch0 in the same cycle: set wins.
        step(1, 4'h1, 0, 0, 1, 0, 16'h0);
        chk("collide_ack pre", reg_do, 16'h003);
        step(1, 4'h0, 0, 0, 1, 0, 16'h0);
        chk("collide_ack virq", 16'(virq_o), 16'h1);
        step(1, 4'h1, 0, 1, 1, 0, 16'h0);
        chk("collide_ack pending", reg_do, 16'h003);
        chk("collide_ack vector", vector_o, 16'h30);
        step(1, 4'h0, 0, 0, 1, 0, 16'h0);

        // ce=0 blocks register writes and edge capture.
        step(0, 4'h0, 0, 0, 0, 1, 16'h0);
        step(1, 4'h0, 0, 0, 0, 0, 16'h0);
        chk("ce0 enable", reg_do, 16'h003);
        step(0, 4'h0, 0, 0, 1, 1, 16'h3);
        step(1, 4'h0, 0, 0, 1, 0, 16'h0);
        chk("ce0 w1c", reg_do, 16'h003);
        step(1, 4'h0, 0, 0, 1, 1, 16'h3);
        chk("w1c both", reg_do, 16'h000);
        step(0, 4'h1, 0, 0, 1, 0, 16'h0);
        step(0, 4'h0, 0, 0, 1, 0, 16'h0);
        step(1, 4'h0, 0, 0, 1, 0, 16'h0);
        chk("ce0 edge", reg_do, 16'h000);
        step(1, 4'h1, 0, 0, 1, 0, 16'h0);
        chk("ce1 edge", reg_do, 16'h001);

        // Level channel ignores write-1-to-clear; edge channel honours it.
        step(1, 4'h9, 0, 0, 1, 0, 16'h0);
        chk("level pend", reg_do, 16'h809);
        step(1, 4'h9, 0, 0, 1, 1, 16'h9);
        chk("level w1c", reg_do, 16'h808);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bk_intc.md
Name: bk_intc

Overview:
- Parametrised vectored interrupt controller for the BK core.
- Generalises the single keyboard interrupt (fixed vector 060/0274, fires only at PSW priority 0) to NCH sources, each with its own bus-request priority, vector, edge/level mode and enable bit.
- Drives the CPU VIRQ input and supplies the vector during the IAKO read.
- Mapped into the 1777xx register space via a two-word register window.

Parameters:
- NCH, 4: number of interrupt sources (1..8).
- PRIO, {3'd4,3'd4,3'd4,3'd4}: packed 3-bit priority per channel; channel i at [3i+2:3i].
- VECTORS, {16'o0100,16'o0274,16'o0060,16'o0060}: packed 16-bit vector per channel; channel i at [16i+15:16i].
- EDGE_MASK, 4'b0011: bit i=1 means channel i latches on a rising edge; 0 means level.
- ENABLE_RST, 4'b0001: enable mask value at reset.
- SPURIOUS_VEC, 16'o0000: vector returned when no channel qualifies at acknowledge.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; all state updates happen only when ce=1, except reset
- src_i  in  NCH  interrupt request lines, synchronous to clk
- psw_pri  in  3  current CPU priority, PSW[7:5]
- virq_o  out  1  vectored interrupt request to CPU
- iako_i  in  1  interrupt acknowledge from CPU; held high through the vector read
- vector_o  out  16  vector presented while iako_i=1
- reg_sel  in  1  register window selected
- reg_adr  in  1  0 = enable register, 1 = pending register
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_di  in  16  write data
- reg_do  out  16  read data; combinational from registers
- ack_ch_o  out  3  index of the channel last acknowledged (debug / LEDs)

Behaviour:
- Reset (sync, any cycle, overrides ce):
  - enable=ENABLE_RST; pending=0; src_q=0.
  - virq_o=0, vector_o=0, ack_ch_o=0, iako_q=0.
  - An in-progress acknowledge is abandoned.
- Pending register, updated on each ce cycle:
  - Edge channel: pending[i] sets when src_i[i] & ~src_q[i]. It clears on acknowledge of i or on a register write-1-to-clear.
  - If a set and a clear happen in the same ce cycle, the set wins.
  - Level channel: pending[i] = src_i[i] registered. Writes to it are ignored and ack does not clear it; the source must deassert.
- Candidate set: cand = pending & enable.
- Winner:
  - Highest PRIO among cand.
  - On a priority tie, the lowest index wins.
  - The winner is computed combinationally from registered state.
- virq_o:
  - Registered, updated each ce: 1 iff a winner exists and PRIO[winner] > psw_pri (strict).
  - psw_pri=7 masks all channels.
  - virq_o is forced 0 while iako_i=1.
- Latency:
  - src_i rising edge at ce cycle N gives pending at N+1 and virq_o at N+2.
  - A psw_pri change affects virq_o one ce cycle later.
- Acknowledge:
  - On the first ce cycle with iako_i=1 and iako_q=0, the block latches vector_o=VECTORS[winner] and ack_ch_o=winner.
  - In that same cycle it clears pending[winner] if the winner is an edge channel.
  - If there is no winner at that instant (request withdrawn), it latches vector_o=SPURIOUS_VEC and clears nothing.
  - vector_o stays stable while iako_i=1. New requests arriving during ack are pended and evaluated after iako_i falls.
  - iako_q tracks iako_i on each ce.
- Registers:
  - adr0 read: {0, enable[NCH-1:0]}. adr0 write: enable <= reg_di[NCH-1:0].
  - adr1 read: {0, src_i level bits in [15:8], pending in [7:0]}.
  - adr1 write: for each edge channel i with reg_di[i]=1, clear pending[i]. Bits for level channels are ignored.
  - Bits above NCH read 0.
  - reg_wr/reg_rd act only when reg_sel=1 and ce=1.
- Disabling a channel whose request is pending drops virq_o on the next ce, but pending is retained. Re-enabling re-raises virq_o.

Decomposition:
- Package bk_intc_pkg:
  - PRIO_W=3, VEC_W=16.
  - Register offsets REG_ENABLE=0, REG_PENDING=1.
  - Function prio_of(PRIO, i) and vec_of(VECTORS, i) for packed-field extraction.
- Sub-module bk_intc_arb:
  - Purely combinational winner select: inputs cand and PRIO; outputs valid, idx, prio.
  - Reused for a future second bus-request level.
- Top module bk_intc holds pending/enable/ack state and the register window.

Test Plan:
- Defaults, psw_pri=0, ch0 edge pulse on src_i[0] → virq_o=1 two ce later. Then iako_i=1 → vector_o=0060, ack_ch_o=0, pending[0]=0, virq_o=0.
- Enable=4'b0011, ch0 and ch1 pulsed in the same cycle, both PRIO=4 → first ack vector 0060, second ack vector 0274 (lowest-index tie-break).
- PRIO ch3=6, ch0=4, ch3 level high with both enabled → ack vector 0100. With psw_pri=6, virq_o=0; dropping psw_pri to 5 → virq_o=1 one ce later.
- Edge pulse on ch1 with enable bit clear → pending reads 0x0002 at adr1 and virq_o=0. Writing 0x0002 to adr1 → pending 0. Re-pulse then enable → virq_o=1.
- virq_o raised, source disabled before iako_i rises → vector_o=SPURIOUS_VEC=0, nothing cleared.
- reset asserted during iako_i=1 with pending=0x3 → next cycle pending=0, enable=0x1, virq_o=0, vector_o=0. A set-vs-clear collision on an edge channel leaves pending=1.
